// File: rtl/schmidl_cox_pkg.sv
// Shared types for the A/B stream aligner: FSM state, per-beat join control
// and the skip-counter width helper.
package schmidl_cox_pkg;

  typedef enum logic {
    ST_SKIP = 1'b0,
    ST_JOIN = 1'b1
  } align_state_e;

  // Per-cycle join decision: whether the pair fires, and its tlast bookkeeping.
  typedef struct packed {
    logic fire;
    logic last;
    logic last_mismatch;
  } join_ctl_t;

  // Counter must hold the value SKIP itself, and never be zero bits wide.
  function automatic int skip_cnt_width(input int skip);
    return (skip > 0) ? $clog2(skip + 1) : 1;
  endfunction

endpackage

// File: rtl/axis_stream_aligner_skid_buffer.sv
// Two-entry AXI-stream output stage (main + skid) with registered valid and a
// registered "space" flag, so the upstream ready never waits on m_tready.
module axis_skid_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tlast,
  input  logic             s_push,
  output logic             s_space,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready
);

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             main_last_q, main_last_d;
  logic             skid_last_q, skid_last_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             drain;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    main_data_d  = main_data_q;
    main_last_d  = main_last_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_valid_d = skid_valid_q;
    drain        = main_valid_q & m_tready;

    if (drain) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_last_d  = skid_last_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    // A push only arrives while the skid is empty, so it lands in main
    // whenever main is free this cycle, otherwise in the skid.
    if (s_push) begin
      if (!main_valid_q || (drain && !skid_valid_q)) begin
        main_data_d  = s_tdata;
        main_last_d  = s_tlast;
        main_valid_d = 1'b1;
      end else begin
        skid_data_d  = s_tdata;
        skid_last_d  = s_tlast;
        skid_valid_d = 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      main_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_last_q  <= main_last_d;
      main_valid_q <= main_valid_d;
      skid_last_q  <= skid_last_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // NOTE: skid payload is only read when skid_valid_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

  assign s_space  = !skid_valid_q;
  assign m_tdata  = main_data_q;
  assign m_tlast  = main_last_q;
  assign m_tvalid = main_valid_q;

endmodule

// File: rtl/axis_stream_aligner.sv
// Joins a direct stream A with a delayed stream B into {A,B} beats, dropping
// the first SKIP beats of every A packet and flagging A/B tlast disagreement.
module axis_stream_aligner
  import schmidl_cox_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKIP  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [WIDTH-1:0]   s_a_tdata,
  input  logic               s_a_tlast,
  input  logic               s_a_tvalid,
  output logic               s_a_tready,
  input  logic [WIDTH-1:0]   s_b_tdata,
  input  logic               s_b_tlast,
  input  logic               s_b_tvalid,
  output logic               s_b_tready,
  output logic [2*WIDTH-1:0] m_axis_tdata,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               last_err
);

  localparam int                 CNT_W       = skip_cnt_width(SKIP);
  localparam logic [CNT_W-1:0]   SKIP_LAST   = CNT_W'((SKIP > 0) ? SKIP - 1 : 0);
  localparam align_state_e       RESET_STATE = (SKIP > 0) ? ST_SKIP : ST_JOIN;

  align_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_err_q, last_err_d;
  logic             space;
  join_ctl_t        ctl;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_err_d = last_err_q;
    ctl        = '0;
    s_a_tready = 1'b0;
    s_b_tready = 1'b0;

    case (state_q)
      ST_SKIP: begin
        s_a_tready = 1'b1;
        if (s_a_tvalid) begin
          // A packet that ends inside the skip window is dropped whole.
          if (s_a_tlast) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == SKIP_LAST) state_d = ST_JOIN;
          end
        end
      end
      ST_JOIN: begin
        ctl.fire          = s_a_tvalid & s_b_tvalid & space;
        ctl.last          = s_a_tlast;
        ctl.last_mismatch = s_a_tlast ^ s_b_tlast;
        s_a_tready        = ctl.fire;
        s_b_tready        = ctl.fire;
        if (ctl.fire) begin
          if (ctl.last_mismatch) last_err_d = 1'b1;
          if (ctl.last && (SKIP > 0)) begin
            state_d = ST_SKIP;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      last_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_err_q <= last_err_d;
    end
  end

  assign last_err = last_err_q;

  axis_skid_buffer #(
    .WIDTH (2 * WIDTH)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .s_tdata  ({s_a_tdata, s_b_tdata}),
    .s_tlast  (ctl.last),
    .s_push   (ctl.fire),
    .s_space  (space),
    .m_tdata  (m_axis_tdata),
    .m_tlast  (m_axis_tlast),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready)
  );

endmodule

// File: doc/axis_stream_aligner.md
AXIS_STREAM_ALIGNER -- requirements
Module: axis_stream_aligner

Interface
REQ-001 Parameter WIDTH, default 32: sample width of each input stream.
REQ-002 Parameter SKIP, default 0: leading A beats discarded per packet before joining; range 0..65535.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 clear  input  1  synchronous flush, same effect as reset.
REQ-006 s_a_tdata/s_a_tlast/s_a_tvalid  input  WIDTH/1/1  direct stream A.
REQ-007 s_a_tready  output  1  ready for stream A.
REQ-008 s_b_tdata/s_b_tlast/s_b_tvalid  input  WIDTH/1/1  delayed stream B, typically from a delay line.
REQ-009 s_b_tready  output  1  ready for stream B.
REQ-010 m_axis_tdata  output  2*WIDTH  joined beat {A,B}, A in upper half.
REQ-011 m_axis_tlast/m_axis_tvalid  output  1/1  tlast is A's tlast; valid flag.
REQ-012 m_axis_tready  input  1  downstream ready.
REQ-013 last_err  output  1  sticky: A/B tlast mismatch seen.

Function
REQ-014 The FSM SHALL have two states: SKIP and JOIN.
REQ-015 Reset/clear SHALL enter SKIP with skip counter 0 when SKIP>0, and JOIN when SKIP=0.
REQ-016 In SKIP, s_a_tready SHALL be 1 and s_b_tready 0; each A handshake increments the counter, with no output.
REQ-017 In SKIP, an A handshake with s_a_tlast=1 SHALL zero the counter and stay in SKIP.
REQ-018 SKIP SHALL go to JOIN on the A handshake that brings the counter to SKIP, provided that beat has tlast=0.
REQ-019 In JOIN, fire = s_a_tvalid & s_b_tvalid & space, where space = skid buffer not full.
REQ-020 In JOIN, s_a_tready SHALL equal s_b_tready SHALL equal fire; no one-sided consumption.
REQ-021 Ready SHALL depend on valid only; no output valid SHALL depend on any ready.
REQ-022 A fired beat SHALL appear on m_axis exactly 1 cycle later if the output is empty or draining; throughput 1 beat/cycle.
REQ-023 A 2-entry output stage (main + skid) SHALL hold data stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 space SHALL be registered, i.e. !skid_valid.
REQ-025 No beat SHALL be lost or duplicated under any m_axis_tready pattern.
REQ-026 A fire with s_a_tlast != s_b_tlast SHALL set last_err, which holds until reset/clear.
REQ-027 A fire with s_a_tlast=1 SHALL return the FSM to SKIP with counter 0 when SKIP>0.
REQ-028 Simultaneous fire and output drain SHALL load the new beat into main with no bubble.

Reset
REQ-029 On reset or clear, the following SHALL all be 0 on the next edge: m_axis_tvalid, m_axis_tlast, m_axis_tdata, skid valid, skip counter and last_err.
REQ-030 Reset/clear mid-packet SHALL discard buffered beats.
REQ-031 After reset/clear, both readies SHALL follow REQ-016/REQ-019 from the next cycle.
REQ-032 clear SHALL take priority over a simultaneous fire.

Structure
REQ-033 The FSM state enum and the join data type SHALL be declared in the shared schmidl_cox_pkg.
REQ-034 The counter width SHALL be $clog2(SKIP+1), minimum 1, as a localparam.
REQ-035 The 2-entry output stage SHALL be a sub-module axis_skid_buffer (WIDTH param, tlast carried).

Verification
REQ-036 SKIP=0, both streams valid continuously, m_axis_tready=1, A=1..8, B=101..108 -> m_axis beats {1,101}..{8,108} in consecutive cycles, first one cycle after first fire.
REQ-037 SKIP=3, A=1..10 tlast on 10, B=1..7 tlast on 7 -> A 1..3 dropped; output {4,1}..{10,7}; tlast on the final beat; last_err=0.
REQ-038 m_axis_tready toggling 1,0,0,1 repeating with random valid gaps on A and B -> output sequence identical to the ideal join; data stable while stalled.
REQ-039 A tlast on beat 4 while B tlast on beat 5 -> last_err=1 after beat 4 fires and remains 1; clear -> last_err=0.
REQ-040 clear asserted with 2 beats buffered and m_axis_tready=0 -> m_axis_tvalid=0 next cycle; the next packet joins correctly from its first beat.
REQ-041 s_b_tvalid=0 for 5 cycles, s_a_tvalid=1, SKIP=0 -> s_a_tready=0 throughout; no output; the join resumes when B becomes valid.
